apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_slave.sv | 108 ++++++++++
 tb/tb_apb_reg_slave.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB register file with byte strobes, programmable wait states and read-only status registers
module apb_reg_slave #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 8,
    parameter int WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(8'h80),
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [ADDR_W-1:0]          PADDR,
    input  logic [DATA_W-1:0]          PWDATA,
    input  logic [DATA_W/8-1:0]        PSTRB,
    output logic [DATA_W-1:0]          PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    input  logic [NUM_REGS*DATA_W-1:0] status_in,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_wr_pulse
);
    localparam int LANES = DATA_W / 8;
    localparam int AL = $clog2(LANES);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state, state_d;
    logic [3:0] wait_cnt, wait_d;
    logic [IW-1:0] idx_q;
    logic write_q, err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] full_idx;
    logic [IW-1:0] idx;
    logic valid, setup, done, commit;

    assign full_idx = PADDR >> AL;
    assign idx = full_idx[IW-1:0];
    assign valid = ((PADDR & ADDR_W'(LANES - 1)) == '0) && (int'(full_idx) < NUM_REGS);
    assign setup = state == IDLE && PSEL && !PENABLE;
    assign PREADY = state == ACCESS && wait_cnt == 4'd0;
    assign done = PREADY && PSEL && PENABLE;
    assign commit = done && write_q && !err_q;
    assign PSLVERR = PREADY && err_q;
    assign PRDATA = PREADY && !write_q && !err_q ? rdata_q : '0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_d;
            wait_cnt <= wait_d;
        end
    end

    // Dropping PSEL mid-access abandons the transfer silently
    always_comb begin
        state_d = state;
        wait_d = wait_cnt;
        if (setup) begin
            state_d = ACCESS;
            wait_d = 4'(WAIT_STATES);
        end else if (state == ACCESS) begin
            if (!PSEL || done) begin
                state_d = IDLE;
                wait_d = 4'd0;
            end else if (wait_cnt != 4'd0) begin
                wait_d = wait_cnt - 4'd1;
            end
        end
    end

    // Read data is snapshotted at setup so it stays stable through wait states
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            idx_q <= '0;
            write_q <= 1'b0;
            err_q <= 1'b0;
            rdata_q <= '0;
        end else if (setup) begin
            idx_q <= idx;
            write_q <= PWRITE;
            err_q <= !valid || (PWRITE && RO_MASK[idx]);
            rdata_q <= !valid ? '0 : RO_MASK[idx] ? status_in[idx*DATA_W +: DATA_W] : regs[idx];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= commit ? NUM_REGS'(1) << idx_q : '0;
            if (commit)
                for (int k = 0; k < LANES; k++)
                    if (PSTRB[k]) regs[idx_q][8*k +: 8] <= PWDATA[8*k +: 8];
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs[i];
    end
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed vector table plus multi-cycle corner sequences for apb_reg_slave
module tb_apb_reg_slave;
    logic clk = 1'b0;
    logic preset, psel, psel3, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0] pstrb;
    logic [255:0] status_in;
    logic [31:0] prdata, prdata3;
    logic pready, pready3, pslverr, pslverr3;
    logic [255:0] reg_q, reg_q3;
    logic [7:0] pulse, pulse3;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_reg_slave dut (
        .PCLK(clk), .PRESET(preset), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata), .PREADY(pready),
        .PSLVERR(pslverr), .status_in(status_in), .reg_q(reg_q), .reg_wr_pulse(pulse)
    );

    apb_reg_slave #(.WAIT_STATES(3)) dut3 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata3), .PREADY(pready3),
        .PSLVERR(pslverr3), .status_in(status_in), .reg_q(reg_q3), .reg_wr_pulse(pulse3)
    );

    typedef struct {
        bit          wr;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] rd;
        bit          err;
        logic [7:0]  pl;
    } vec_t;

    vec_t tv [16];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic xfer(input bit slow, input bit wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic err,
                        output int lat, output logic [7:0] pl);
        @(posedge clk); #1;
        psel = !slow; psel3 = slow; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 2;
        @(negedge clk);
        while (!(slow ? pready3 : pready) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = slow ? prdata3 : prdata;
        err = slow ? pslverr3 : pslverr;
        @(posedge clk); #1;
        psel = 1'b0; psel3 = 1'b0; penable = 1'b0;
        @(negedge clk);
        pl = slow ? pulse3 : pulse;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic err;
        int lat;
        logic [7:0] pl;
        tv[0]  = '{1'b0, 12'h004, 32'h0,        4'h0, 32'h0,        1'b0, 8'h00};
        tv[1]  = '{1'b1, 12'h008, 32'hDEADBEEF, 4'h5, 32'h0,        1'b0, 8'h04};
        tv[2]  = '{1'b0, 12'h008, 32'h0,        4'h0, 32'h00AD00EF, 1'b0, 8'h00};
        tv[3]  = '{1'b1, 12'h01C, 32'h12345678, 4'hF, 32'h0,        1'b1, 8'h00};
        tv[4]  = '{1'b0, 12'h01C, 32'h0,        4'h0, 32'h55,       1'b0, 8'h00};
        tv[5]  = '{1'b0, 12'h020, 32'h0,        4'h0, 32'h0,        1'b1, 8'h00};
        tv[6]  = '{1'b1, 12'h002, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 8'h00};
        tv[7]  = '{1'b1, 12'h020, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 8'h00};
        tv[8]  = '{1'b0, 12'h000, 32'h0,        4'h0, 32'h0,        1'b0, 8'h00};
        tv[9]  = '{1'b1, 12'h00C, 32'hCAFEF00D, 4'h0, 32'h0,        1'b0, 8'h08};
        tv[10] = '{1'b0, 12'h00C, 32'h0,        4'h0, 32'h0,        1'b0, 8'h00};
        tv[11] = '{1'b1, 12'h014, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0, 8'h20};
        tv[12] = '{1'b0, 12'h014, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 8'h00};
        tv[13] = '{1'b1, 12'h008, 32'h11223344, 4'hA, 32'h0,        1'b0, 8'h04};
        tv[14] = '{1'b0, 12'h008, 32'h0,        4'h0, 32'h11AD33EF, 1'b0, 8'h00};
        tv[15] = '{1'b0, 12'h3FC, 32'h0,        4'h0, 32'h0,        1'b1, 8'h00};

        status_in = '0;
        status_in[7*32 +: 32] = 32'h55;
        status_in[3*32 +: 32] = 32'h33333333;
        preset = 1'b1; psel = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst pready", pready, 1'b0);
        chk("rst pslverr", pslverr, 1'b0);
        chk("rst prdata", prdata, 32'h0);
        chk("rst pulse", pulse, 8'h0);
        chk("rst reg_q", reg_q, 256'h0);
        @(posedge clk); #1;
        preset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, tv[i].wr, tv[i].a, tv[i].d, tv[i].s, rd, err, lat, pl);
            chk($sformatf("v%0d prdata", i), rd, tv[i].rd);
            chk($sformatf("v%0d pslverr", i), err, tv[i].err);
            chk($sformatf("v%0d latency", i), lat, 2);
            chk($sformatf("v%0d pulse", i), pl, tv[i].pl);
        end
        chk("reg_q r2", reg_q[2*32 +: 32], 32'h11AD33EF);
        chk("reg_q r3", reg_q[3*32 +: 32], 32'h0);
        chk("reg_q r5", reg_q[5*32 +: 32], 32'hA5A5A5A5);
        chk("reg_q r7 ro", reg_q[7*32 +: 32], 32'h0);

        // stray PENABLE while idle must not start a transfer
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'hFF; pstrb = 4'hF;
        @(negedge clk);
        chk("stray pready c1", pready, 1'b0);
        @(negedge clk);
        chk("stray pready c2", pready, 1'b0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("stray pulse", pulse, 8'h0);

        // back-to-back write then read of the same register
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h018; pwdata = 32'h77; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("b2b wr pready", pready, 1'b1);
        @(posedge clk); #1;
        penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        chk("b2b pulse", pulse, 8'h40);
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("b2b rd pready", pready, 1'b1);
        chk("b2b rd prdata", prdata, 32'h77);
        chk("b2b pulse once", pulse, 8'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;

        // wait states
        xfer(1'b1, 1'b1, 12'h000, 32'h1, 4'hF, rd, err, lat, pl);
        chk("ws3 wr latency", lat, 5);
        chk("ws3 wr pslverr", err, 1'b0);
        chk("ws3 wr pulse", pl, 8'h01);
        xfer(1'b1, 1'b0, 12'h000, 32'h0, 4'h0, rd, err, lat, pl);
        chk("ws3 rd latency", lat, 5);
        chk("ws3 rd prdata", rd, 32'h1);

        // abort by dropping PSEL during wait states
        @(posedge clk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h99; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("abort waiting", pready3, 1'b0);
        chk("abort prdata low", prdata3, 32'h0);
        @(posedge clk); #1;
        psel3 = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort pulse", pulse3, 8'h0);
        chk("abort pslverr", pslverr3, 1'b0);
        xfer(1'b1, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, lat, pl);
        chk("abort rd prdata", rd, 32'h0);
        chk("abort rd latency", lat, 5);

        // reset during the access cycle of a write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1; preset = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; preset = 1'b0;
        @(negedge clk);
        chk("midrst pulse", pulse, 8'h0);
        chk("midrst pready", pready, 1'b0);
        xfer(1'b0, 1'b0, 12'h004, 32'h0, 4'h0, rd, err, lat, pl);
        chk("midrst rd prdata", rd, 32'h0);
        chk("midrst rd latency", lat, 2);
        chk("midrst rd pslverr", err, 1'b0);
        xfer(1'b0, 1'b0, 12'h008, 32'h0, 4'h0, rd, err, lat, pl);
        chk("midrst r2 cleared", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
